// File: rtl/toggle_cover_pkg.sv
// Shared types and helpers for the toggle coverage detector.
package toggle_cover_pkg;

  localparam int MAX_WIDTH = 64;
  localparam int POP_W     = 7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } arm_state_e;

  // Width needed to hold a count from 0 up to and including w.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  // Number of set bits in a vector of up to MAX_WIDTH bits.
  function automatic logic [POP_W-1:0] popcount(input logic [MAX_WIDTH-1:0] v);
    logic [POP_W-1:0] c;
    c = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      c = c + POP_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/toggle_cover_bit.sv
// Per-bit toggle cell: remembers the last sample, sticky rise/fall flags,
// and pulses valid once when both directions have been seen.
module toggle_cover_bit (
  input  logic clock,
  input  logic reset,
  input  logic sig,
  input  logic enable,
  input  logic clear,
  input  logic armed,
  output logic valid,
  output logic covered,
  output logic covered_nxt
);

  logic prev_q, prev_d;
  logic rise_seen_q, rise_seen_d;
  logic fall_seen_q, fall_seen_d;
  logic covered_q, covered_d;
  logic valid_q, valid_d;
  logic rise, fall;

  assign rise = sig & ~prev_q;
  assign fall = ~sig & prev_q;

  // Next-state for the cell; clear wins, prev is left alone because the
  // re-arming edge reloads it anyway.
  always_comb begin
    prev_d      = prev_q;
    rise_seen_d = rise_seen_q;
    fall_seen_d = fall_seen_q;
    covered_d   = covered_q;
    valid_d     = 1'b0;
    if (clear) begin
      rise_seen_d = 1'b0;
      fall_seen_d = 1'b0;
      covered_d   = 1'b0;
    end else if (enable) begin
      prev_d = sig;
      if (armed) begin
        rise_seen_d = rise_seen_q | rise;
        fall_seen_d = fall_seen_q | fall;
        valid_d     = ~covered_q & rise_seen_d & fall_seen_d;
        covered_d   = covered_q | valid_d;
      end
    end
  end

  // Cell state registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_q      <= 1'b0;
      rise_seen_q <= 1'b0;
      fall_seen_q <= 1'b0;
      covered_q   <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      rise_seen_q <= rise_seen_d;
      fall_seen_q <= fall_seen_d;
      covered_q   <= covered_d;
      valid_q     <= valid_d;
    end
  end

  assign valid       = valid_q;
  assign covered     = covered_q;
  assign covered_nxt = covered_d;

endmodule

// File: rtl/toggle_cover_detect.sv
// Toggle coverage detector: WIDTH toggle cells sharing one arming state,
// plus a registered covered count and all-covered flag.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | after reset/clear; next enabled edge only samples sig
// ST_ARMED | prev holds a valid sample; enabled edges detect toggles
module toggle_cover_detect
  import toggle_cover_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] sig,
  input  logic             enable,
  input  logic             clear,
  output logic [WIDTH-1:0] valid,
  output logic [WIDTH-1:0] covered,
  output logic [CNT_W-1:0] covered_count,
  output logic             all_covered
);

  arm_state_e       state_q, state_d;
  logic             armed;
  logic [WIDTH-1:0] covered_nxt;
  logic [CNT_W-1:0] count_q, count_d;
  logic             all_q, all_d;

  // Arming state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Arming next state: clear disarms, any enabled edge arms.
  always_comb begin
    state_d = state_q;
    if (clear)       state_d = ST_IDLE;
    else if (enable) state_d = ST_ARMED;
  end

  // Arming output decode.
  always_comb begin
    armed = (state_q == ST_ARMED);
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    toggle_cover_bit u_bit (
      .clock       (clock),
      .reset       (reset),
      .sig         (sig[gi]),
      .enable      (enable),
      .clear       (clear),
      .armed       (armed),
      .valid       (valid[gi]),
      .covered     (covered[gi]),
      .covered_nxt (covered_nxt[gi])
    );
  end

  // Count is taken from the cells' next covered value so it lands on the
  // same edge as covered itself.
  always_comb begin
    count_d = CNT_W'(popcount(MAX_WIDTH'(covered_nxt)));
    all_d   = (count_d == CNT_W'(WIDTH));
  end

  // Registered summary outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      all_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      all_q   <= all_d;
    end
  end

  assign covered_count = count_q;
  assign all_covered   = all_q;

endmodule

// File: tb/tb_toggle_cover_detect.sv
// Directed bench for toggle_cover_detect with hand-computed expectations.
module tb_toggle_cover_detect;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clock;
  logic             reset;
  logic [WIDTH-1:0] sig;
  logic             enable;
  logic             clear;
  logic [WIDTH-1:0] valid;
  logic [WIDTH-1:0] covered;
  logic [CNT_W-1:0] covered_count;
  logic             all_covered;

  int n_vec;
  int n_err;

  toggle_cover_detect #(.WIDTH(WIDTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .sig           (sig),
    .enable        (enable),
    .clear         (clear),
    .valid         (valid),
    .covered       (covered),
    .covered_count (covered_count),
    .all_covered   (all_covered)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive inputs on the falling edge, then sample 1ns after the rising edge.
  task automatic step(input logic [WIDTH-1:0] s, input logic en, input logic clr);
    @(negedge clock);
    sig    = s;
    enable = en;
    clear  = clr;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] v, input logic [7:0] c,
                         input logic [3:0] n, input logic a);
    chk({tag, ".valid"},   64'(valid), 64'(v));
    chk({tag, ".covered"}, 64'(covered), 64'(c));
    chk({tag, ".count"},   64'(covered_count), 64'(n));
    chk({tag, ".all"},     64'(all_covered), 64'(a));
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    reset  = 1'b1;
    sig    = '0;
    enable = 1'b0;
    clear  = 1'b0;
    #3;
    chk_all("reset", 8'h00, 8'h00, 4'd0, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    // Arming edge with all ones, then hold: nothing detected.
    step(8'hFF, 1'b1, 1'b0);
    chk_all("arm_ff", 8'h00, 8'h00, 4'd0, 1'b0);
    step(8'hFF, 1'b1, 1'b0);
    chk("hold_ff1.valid", 64'(valid), 64'h00);
    step(8'hFF, 1'b1, 1'b0);
    chk("hold_ff2.valid", 64'(valid), 64'h00);

    // Clear, re-arm at zero, then a full toggle on bit 0.
    step(8'h00, 1'b1, 1'b1);
    chk_all("clr0", 8'h00, 8'h00, 4'd0, 1'b0);
    step(8'h00, 1'b1, 1'b0);
    chk("rearm0.valid", 64'(valid), 64'h00);
    step(8'h01, 1'b1, 1'b0);
    chk("b0_rise.valid", 64'(valid), 64'h00);
    step(8'h00, 1'b1, 1'b0);
    chk_all("b0_fall", 8'h01, 8'h01, 4'd1, 1'b0);
    step(8'h00, 1'b1, 1'b0);
    chk_all("b0_after", 8'h00, 8'h01, 4'd1, 1'b0);

    // Bit 0 again: already covered, no second pulse.
    step(8'h01, 1'b1, 1'b0);
    chk("b0_rep_rise.valid", 64'(valid), 64'h00);
    step(8'h00, 1'b1, 1'b0);
    chk_all("b0_rep_fall", 8'h00, 8'h01, 4'd1, 1'b0);

    // All bits toggle: seven new completions in one word.
    step(8'hFF, 1'b1, 1'b0);
    chk("all_rise.valid", 64'(valid), 64'h00);
    step(8'h00, 1'b1, 1'b0);
    chk_all("all_fall", 8'hFE, 8'hFF, 4'd8, 1'b1);
    step(8'h00, 1'b1, 1'b0);
    chk_all("all_after", 8'h00, 8'hFF, 4'd8, 1'b1);

    // Toggle on bit 1 while disabled is invisible.
    step(8'h00, 1'b1, 1'b1);
    chk_all("clr1", 8'h00, 8'h00, 4'd0, 1'b0);
    step(8'h00, 1'b1, 1'b0);
    step(8'h02, 1'b0, 1'b0);
    chk("dis_rise.valid", 64'(valid), 64'h00);
    step(8'h00, 1'b0, 1'b0);
    chk("dis_fall.valid", 64'(valid), 64'h00);
    step(8'h00, 1'b1, 1'b0);
    chk_all("reen", 8'h00, 8'h00, 4'd0, 1'b0);
    // Bit 1 needs both directions while enabled.
    step(8'h02, 1'b1, 1'b0);
    chk("b1_rise.valid", 64'(valid), 64'h00);
    step(8'h00, 1'b1, 1'b0);
    chk_all("b1_fall", 8'h02, 8'h02, 4'd1, 1'b0);

    // Clear on the edge that would complete bit 2.
    step(8'h04, 1'b1, 1'b0);
    chk("b2_rise.valid", 64'(valid), 64'h00);
    step(8'h00, 1'b1, 1'b1);
    chk_all("clr_win", 8'h00, 8'h00, 4'd0, 1'b0);
    step(8'h00, 1'b1, 1'b0);
    chk("rearm2.valid", 64'(valid), 64'h00);

    // Rise while disabled is caught on re-enable against the held prev.
    step(8'h04, 1'b0, 1'b0);
    step(8'h04, 1'b1, 1'b0);
    chk("held_prev.valid", 64'(valid), 64'h00);
    step(8'h00, 1'b1, 1'b0);
    chk_all("b2_done", 8'h04, 8'h04, 4'd1, 1'b0);

    // Asynchronous reset in the middle of the pulse.
    #2;
    reset = 1'b1;
    #1;
    chk_all("async_rst", 8'h00, 8'h00, 4'd0, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
